// File: rtl/button_event_arbiter.sv
// Debounces N raw push-buttons, keeps a toggle bit per button, and queues one pending
// press per button that a round-robin arbiter serialises onto a valid/ready event port.
module button_event_arbiter #(
   parameter int N          = 4,
   parameter int DEB_CYCLES = 4,
   parameter int CW         = 8,
   parameter int IDW        = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   button,
   input  logic           ev_ready,
   input  logic           clr_overrun,
   output logic           ev_valid,
   output logic [IDW-1:0] ev_id,
   output logic [N-1:0]   toggle_state,
   output logic [N-1:0]   overrun
);

   typedef enum logic {IDLE, GRANT} state_t;

   logic [N-1:0]   sync1_q, sync2_q;
   logic [N-1:0]   db_q;
   logic [N-1:0]   rise;
   logic [N-1:0]   consume;
   logic [N-1:0]   pend_q, pend_d;
   logic [N-1:0]   toggle_q, toggle_d;
   logic [N-1:0]   overrun_q, overrun_d;
   logic [IDW-1:0] ptr_q, ev_id_q, sel;
   logic           ev_valid_q;
   state_t         state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= button;
         sync2_q <= sync1_q;
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_deb
         logic          db_bit_q;
         logic [CW-1:0] cnt_q;

         // Any sample that agrees with the accepted level restarts the stability count.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               db_bit_q <= 1'b0;
               cnt_q    <= '0;
            end else if (sync2_q[gi] == db_bit_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
               db_bit_q <= sync2_q[gi];
               cnt_q    <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign db_q[gi] = db_bit_q;
         assign rise[gi] = sync2_q[gi] && !db_bit_q && (cnt_q == CW'(DEB_CYCLES - 1));
      end
   endgenerate

   always_comb begin
      consume = '0;
      for (int i = 0; i < N; i++)
         consume[i] = (state_q == GRANT) && ev_ready && (ev_id_q == IDW'(i));
   end

   // A press landing on the handshake edge of its own channel re-arms pend without overrun.
   always_comb begin
      pend_d    = (pend_q & ~consume) | rise;
      toggle_d  = toggle_q ^ rise;
      overrun_d = clr_overrun ? '0 : overrun_q;
      overrun_d = overrun_d | (rise & pend_q & ~consume);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q    <= '0;
         toggle_q  <= '0;
         overrun_q <= '0;
      end else begin
         pend_q    <= pend_d;
         toggle_q  <= toggle_d;
         overrun_q <= overrun_d;
      end
   end

   // Scanning from the far end backwards leaves the first pending index at or after ptr.
   always_comb begin
      int idx;
      idx = 0;
      sel = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N)
            idx = idx - N;
         if (pend_q[idx])
            sel = IDW'(idx);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         ev_valid_q <= 1'b0;
         ev_id_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|pend_q) begin
                  ev_id_q    <= sel;
                  ev_valid_q <= 1'b1;
                  state_q    <= GRANT;
               end
            end
            GRANT: begin
               if (ev_ready) begin
                  ev_valid_q <= 1'b0;
                  ptr_q      <= (ev_id_q == IDW'(N - 1)) ? '0 : ev_id_q + 1'b1;
                  state_q    <= IDLE;
               end
            end
         endcase
      end
   end

   assign ev_valid     = ev_valid_q;
   assign ev_id        = ev_id_q;
   assign toggle_state = toggle_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scenario bench for button_event_arbiter: expected event ids are queued as presses are
// driven and compared by a monitor whenever the DUT completes a handshake.
module tb_button_event_arbiter;
   localparam int N   = 4;
   localparam int DEB = 4;
   localparam int CW  = 8;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   button;
   logic           ev_ready;
   logic           clr_overrun;
   logic           ev_valid;
   logic [IDW-1:0] ev_id;
   logic [N-1:0]   toggle_state;
   logic [N-1:0]   overrun;

   int pass_cnt = 0;
   int total    = 0;
   logic [IDW-1:0] exp_q[$];
   logic [IDW-1:0] exp_id;

   button_event_arbiter #(.N(N), .DEB_CYCLES(DEB), .CW(CW), .IDW(IDW)) dut (
      .clk          (clk),
      .reset        (reset),
      .button       (button),
      .ev_ready     (ev_ready),
      .clr_overrun  (clr_overrun),
      .ev_valid     (ev_valid),
      .ev_id        (ev_id),
      .toggle_state (toggle_state),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   // Handshake monitor: valid and ready both high at the falling edge commit on the next rise.
   always @(negedge clk) begin
      if (!reset && ev_valid && ev_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got id %0d, required no event", ev_id);
         end else begin
            exp_id = exp_q.pop_front();
            if (ev_id !== exp_id)
               $display("FAIL event_id: got %0d, required %0d", ev_id, exp_id);
            else begin
               pass_cnt++;
               $display("event id %0d accepted at %0t", ev_id, $time);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; button = '0; ev_ready = 1'b0; clr_overrun = 1'b0;
      tick(3);
      total++; if (ev_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", ev_valid); else pass_cnt++;
      total++; if (ev_id !== '0) $display("FAIL reset_id: got %0d, required 0", ev_id); else pass_cnt++;
      total++; if (toggle_state !== '0) $display("FAIL reset_toggle: got %b, required 0000", toggle_state); else pass_cnt++;
      total++; if (overrun !== '0) $display("FAIL reset_overrun: got %b, required 0000", overrun); else pass_cnt++;
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_clean_press();
      ev_ready = 1'b1;
      exp_q.push_back(2'd1);
      button[1] = 1'b1;
      tick(5);
      total++; if (toggle_state !== 4'b0000) $display("FAIL clean_toggle_early: got %b, required 0000", toggle_state); else pass_cnt++;
      tick(1);
      total++; if (toggle_state !== 4'b0010) $display("FAIL clean_toggle_edge6: got %b, required 0010", toggle_state); else pass_cnt++;
      tick(1);
      total++; if (ev_valid !== 1'b1 || ev_id !== 2'd1) $display("FAIL clean_offer: got valid %b id %0d, required valid 1 id 1", ev_valid, ev_id); else pass_cnt++;
      tick(1);
      total++; if (ev_valid !== 1'b0) $display("FAIL clean_one_cycle: got valid %b, required 0", ev_valid); else pass_cnt++;
      tick(4);
      button[1] = 1'b0;
      tick(12);
      total++; if (toggle_state !== 4'b0010 || ev_valid !== 1'b0) $display("FAIL clean_release: got toggle %b valid %b, required 0010 0", toggle_state, ev_valid); else pass_cnt++;
      total++; if (exp_q.size() != 0) $display("FAIL clean_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_bounce();
      logic [3:0] pattern;
      pattern = 4'b0101;
      ev_ready = 1'b1;
      exp_q.push_back(2'd0);
      for (int i = 0; i < 4; i++) begin
         button[0] = pattern[i];
         tick(1);
      end
      button[0] = 1'b1;
      tick(12);
      total++; if (toggle_state !== 4'b0011) $display("FAIL bounce_toggle: got %b, required 0011", toggle_state); else pass_cnt++;
      total++; if (exp_q.size() != 0) $display("FAIL bounce_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
      button[0] = 1'b0;
      tick(10);
      button[3] = 1'b1;
      tick(3);
      button[3] = 1'b0;
      tick(10);
      total++; if (toggle_state !== 4'b0011 || ev_valid !== 1'b0) $display("FAIL glitch_ignored: got toggle %b valid %b, required 0011 0", toggle_state, ev_valid); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      ev_ready = 1'b1;
      exp_q.push_back(2'd3);
      exp_q.push_back(2'd0);
      button[0] = 1'b1; button[3] = 1'b1;
      tick(12);
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick(1);
      total++; if (exp_q.size() != 0) $display("FAIL rr_pair_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
      total++; if (toggle_state !== 4'b1010) $display("FAIL rr_pair_toggle: got %b, required 1010", toggle_state); else pass_cnt++;
      button = '0;
      tick(10);
      exp_q.push_back(2'd3);
      button[3] = 1'b1;
      tick(12);
      button[3] = 1'b0;
      tick(10);
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
      button = 4'b1101;
      tick(14);
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick(1);
      total++; if (exp_q.size() != 0) $display("FAIL rr_triple_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
      total++; if (toggle_state !== 4'b1111) $display("FAIL rr_triple_toggle: got %b, required 1111", toggle_state); else pass_cnt++;
      button = '0;
      tick(10);
   endtask

   task automatic test_backpressure();
      ev_ready = 1'b0;
      button[2] = 1'b1;
      tick(8);
      total++; if (ev_valid !== 1'b1 || ev_id !== 2'd2) $display("FAIL bp_offer: got valid %b id %0d, required 1 2", ev_valid, ev_id); else pass_cnt++;
      button[2] = 1'b0;
      tick(8);
      button[2] = 1'b1;
      tick(8);
      total++; if (ev_valid !== 1'b1 || ev_id !== 2'd2) $display("FAIL bp_hold: got valid %b id %0d, required 1 2", ev_valid, ev_id); else pass_cnt++;
      total++; if (overrun !== 4'b0100) $display("FAIL bp_overrun: got %b, required 0100", overrun); else pass_cnt++;
      exp_q.push_back(2'd2);
      ev_ready = 1'b1;
      tick(1);
      total++; if (ev_valid !== 1'b0) $display("FAIL bp_accept: got valid %b, required 0", ev_valid); else pass_cnt++;
      tick(1);
      total++; if (ev_valid !== 1'b0) $display("FAIL bp_pend_cleared: got valid %b, required 0", ev_valid); else pass_cnt++;
      tick(3);
      total++; if (overrun !== 4'b0100) $display("FAIL bp_sticky: got %b, required 0100", overrun); else pass_cnt++;
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
      total++; if (overrun !== 4'b0000) $display("FAIL bp_clear: got %b, required 0000", overrun); else pass_cnt++;
      total++; if (toggle_state !== 4'b1111) $display("FAIL bp_toggle: got %b, required 1111", toggle_state); else pass_cnt++;
      button[2] = 1'b0;
      tick(10);
   endtask

   task automatic test_collision();
      ev_ready = 1'b0;
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd1);
      button[1] = 1'b1;
      tick(8);
      total++; if (ev_valid !== 1'b1 || ev_id !== 2'd1) $display("FAIL col_offer: got valid %b id %0d, required 1 1", ev_valid, ev_id); else pass_cnt++;
      button[1] = 1'b0;
      tick(8);
      button[1] = 1'b1;
      tick(5);
      ev_ready = 1'b1;
      tick(1);
      total++; if (ev_valid !== 1'b0 || toggle_state !== 4'b1111) $display("FAIL col_edge: got valid %b toggle %b, required 0 1111", ev_valid, toggle_state); else pass_cnt++;
      tick(1);
      total++; if (ev_valid !== 1'b1 || ev_id !== 2'd1) $display("FAIL col_reoffer: got valid %b id %0d, required 1 1", ev_valid, ev_id); else pass_cnt++;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick(1);
      total++; if (exp_q.size() != 0) $display("FAIL col_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
      total++; if (overrun !== 4'b0000) $display("FAIL col_overrun: got %b, required 0000", overrun); else pass_cnt++;
      button[1] = 1'b0;
      tick(10);
   endtask

   task automatic test_reset_in_grant();
      ev_ready = 1'b0;
      button[0] = 1'b1;
      tick(8);
      button[0] = 1'b0;
      tick(8);
      button[0] = 1'b1;
      tick(8);
      total++; if (ev_valid !== 1'b1 || overrun !== 4'b0001) $display("FAIL rst_pre: got valid %b overrun %b, required 1 0001", ev_valid, overrun); else pass_cnt++;
      button = '0;
      reset = 1'b1;
      #2;
      total++; if (ev_valid !== 1'b0 || toggle_state !== '0 || overrun !== '0) $display("FAIL rst_async: got valid %b toggle %b overrun %b, required 0 0000 0000", ev_valid, toggle_state, overrun); else pass_cnt++;
      reset = 1'b0;
      ev_ready = 1'b1;
      tick(20);
      total++; if (ev_valid !== 1'b0 || exp_q.size() != 0) $display("FAIL rst_no_stale: got valid %b queue %0d, required 0 0", ev_valid, exp_q.size()); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_round_robin();
      test_backpressure();
      test_collision();
      test_reset_in_grant();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Debounces N raw mechanical button inputs and keeps a per-button toggle state (press toggles, release ignored).
- Queues one pending press event per button.
- A round-robin arbiter serialises pending events onto a single valid/ready event port.
- Sits between the board push-buttons and any consumer that accepts one button event at a time, replacing per-button stateful FSMs.

Parameters:
- N, 4, number of button channels (2..16).
- DEB_CYCLES, 4, consecutive stable synchronised samples required to accept a level change (2..255).
- CW, 8, debounce counter width; must hold DEB_CYCLES-1.
- IDW, 2, width of ev_id; must satisfy 2^IDW >= N.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- button  in  N  raw asynchronous, bouncy button levels; 1 = pressed.
- ev_ready  in  1  consumer accepts ev_id on a rising edge while ev_valid=1.
- clr_overrun  in  1  synchronous clear of all overrun bits.
- ev_valid  out  1  event available.
- ev_id  out  IDW  index of the pressed button.
- toggle_state  out  N  debounced toggle per button.
- overrun  out  N  sticky flag: press lost because one was already pending.

Behaviour:
- Reset (async, immediate):
  - sync stages, debounced levels db, counters, pend, toggle_state, overrun, ev_valid and ev_id all go to 0.
  - Arbiter pointer ptr=0; state IDLE.
  - Asserting reset during GRANT drops the offered event.
- Synchroniser: 2 flops per channel; s[i] is the second stage.
- Debounce, per channel:
  - If s[i]==db[i]: cnt[i]<=0.
  - Else if cnt[i]==DEB_CYCLES-1: db[i]<=s[i] and cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - Any bounce back to db[i] restarts the count.
  - Raw-to-db latency for a clean edge is 2+DEB_CYCLES clocks.
- Press detect: on the same edge where db[i] goes 0->1:
  - toggle_state[i] inverts.
  - pend[i] is set.
  - If pend[i] was already 1 and is not being consumed on that edge, overrun[i] is set and the events merge (pend stays 1).
  - A db 1->0 transition has no effect.
- Overrun: sticky; cleared only by clr_overrun or reset. If a set and clr_overrun coincide, the set wins.
- Arbiter FSM, states IDLE and GRANT:
  - IDLE, pend==0: stay; ev_valid=0.
  - IDLE, pend!=0: select the first pending index scanning ptr, ptr+1, … modulo N. Register ev_id<=sel and ev_valid<=1, go to GRANT.
  - A pend bit set on edge k gives ev_valid=1 after edge k+1.
  - GRANT: ev_valid and ev_id are held stable until an edge with ev_ready=1.
  - On that edge: pend[ev_id]<=0, ptr<=(ev_id==N-1)?0:ev_id+1, ev_valid<=0, go to IDLE.
  - Consecutive events are therefore at least 2 cycles apart.
- Simultaneous events:
  - Press on channel ev_id on the handshake edge: pend[ev_id] stays 1, no overrun; the event is re-offered later.
  - Presses on several channels on the same edge all set pend; order follows round robin from ptr.
  - ev_ready while ev_valid=0 is ignored.
- Width rules:
  - ptr and ev_id are IDW bits; the modulo-N wrap is explicit for non-power-of-two N.
  - Unused ev_id codes never appear.

Test Plan:
- Clean press (N=4, DEB=4): button[1] 0->1 held 12 cycles, ev_ready=1 -> toggle_state[1]=1 exactly 6 edges after the raw rise; ev_valid=1, ev_id=1 one edge later for one cycle; releasing button[1] produces no event.
- Bounce: button[0] alternates 1,0,1,0 for 4 cycles then holds 1 -> exactly one event id 0, toggle_state[0] 0->1 once; a 3-cycle glitch (< DEB) produces no event.
- Round robin: after accepting id 0 (ptr=1), press ch0 and ch3 on the same edge with ev_ready=1 -> events 3 then 0. Pressing ch0, ch2 and ch3 with ptr=0 -> 0, 2, 3.
- Backpressure and overrun: ev_ready=0 with id 2 offered; press ch2 again -> ev_id holds 2, overrun[2]=1. Raising ev_ready gives one event and pend[2]=0. Pulsing clr_overrun -> overrun=0.
- Handshake collision: ch1 press debounces on the same edge as the handshake of id 1 -> a second id 1 event follows, overrun[1]=0.
- Async reset in GRANT: reset pulsed mid-cycle -> ev_valid, toggle_state and overrun read 0 before the next edge; no stale event after reset deasserts.
